// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if
//   Handshake and control bus between the AES round sequencer and the rest of
//   the iterative AES core (host side plus key expander / state datapath).
//
//   Signals:
//     start, decrypt            host -> sequencer   request and mode
//     ready, load_en, done      sequencer -> host   idle, accept pulse, result pulse
//     kx_en, kx_idx, kx_kind,   sequencer -> key expander  (one word per cycle)
//     kx_rcon
//     rnd_en, rnd_idx,          sequencer -> state datapath (one round per cycle)
//     rnd_first, rnd_last
//
//   Modports: master = host/datapath side, slave = sequencer.
interface aes_round_sequencer_if;
  logic       start;
  logic       decrypt;
  logic       ready;
  logic       load_en;
  logic       kx_en;
  logic [5:0] kx_idx;
  logic [1:0] kx_kind;
  logic [7:0] kx_rcon;
  logic       rnd_en;
  logic [3:0] rnd_idx;
  logic       rnd_first;
  logic       rnd_last;
  logic       done;

  modport master (
    output start, decrypt,
    input  ready, load_en, kx_en, kx_idx, kx_kind, kx_rcon,
    input  rnd_en, rnd_idx, rnd_first, rnd_last, done
  );

  modport slave (
    input  start, decrypt,
    output ready, load_en, kx_en, kx_idx, kx_kind, kx_rcon,
    output rnd_en, rnd_idx, rnd_first, rnd_last, done
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Control sequencer for the iterative AES core (AES-128/192/256 chosen by
//   KEY_BITS at elaboration). Issues one key-expansion word and at most one
//   round per cycle; in encrypt the two streams overlap, each round issuing as
//   soon as its four round-key words exist. Rcon is produced by xtime in
//   GF(2^8) rather than decoded from a counter.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-low
//     bus    aes_round_sequencer_if.slave (start/decrypt in; ready, load_en,
//            kx_*, rnd_*, done out)
//
//   Configuration macro: AES_SEQ_DECRYPT_EN
//     defined   - decrypt input honoured: full expansion first (EXPAND), then
//                 rounds NR..0.
//     undefined - decrypt ignored (treated as 0); EXPAND not built.
//
//   All outputs decode registered state; only load_en (= ready & start) has a
//   combinational path from an input.
module aes_round_sequencer #(
  parameter int KEY_BITS = 128
) (
  input logic                   clk,
  input logic                   reset,
  aes_round_sequencer_if.slave  bus
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] NW_W   = 6'(NW);
  localparam logic [3:0] NR_W   = 4'(NR);
  localparam logic [2:0] P_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_round_sequencer: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef AES_SEQ_DECRYPT_EN
    EXPAND = 2'd1,
`endif
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [5:0] wc, wc_n;       // next key word to generate
  logic [2:0] p, p_n;         // phase of wc within an NK-word group
  logic [3:0] rc, rc_n;       // rounds issued so far
  logic [7:0] rcon, rcon_n;
  logic       dec_q;
  logic       kx_go;
  logic       rnd_go;
  logic [6:0] need;           // words required before round rc may issue

`ifdef AES_SEQ_DECRYPT_EN
  logic dec_n;
`else
  logic unused_decrypt;
  assign unused_decrypt = bus.decrypt;
  assign dec_q          = 1'b0;
`endif

  assign need = {1'b0, rc, 2'b00} + 7'd4;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_n       = state;
    wc_n          = wc;
    p_n           = p;
    rc_n          = rc;
    rcon_n        = rcon;
`ifdef AES_SEQ_DECRYPT_EN
    dec_n         = dec_q;
`endif
    kx_go         = 1'b0;
    rnd_go        = 1'b0;
    bus.ready     = 1'b0;
    bus.load_en   = 1'b0;
    bus.kx_en     = 1'b0;
    bus.kx_idx    = 6'd0;
    bus.kx_kind   = 2'd0;
    bus.kx_rcon   = 8'h00;
    bus.rnd_en    = 1'b0;
    bus.rnd_idx   = 4'd0;
    bus.rnd_first = 1'b0;
    bus.rnd_last  = 1'b0;
    bus.done      = 1'b0;

    case (state)
      IDLE: begin
        bus.ready   = 1'b1;
        bus.load_en = bus.start;
        if (bus.start) begin
          wc_n   = NK_W;
          p_n    = 3'd0;
          rc_n   = 4'd0;
          rcon_n = 8'h01;
`ifdef AES_SEQ_DECRYPT_EN
          dec_n   = bus.decrypt;
          state_n = bus.decrypt ? EXPAND : ROUND;
`else
          state_n = ROUND;
`endif
        end
      end
`ifdef AES_SEQ_DECRYPT_EN
      EXPAND: begin
        kx_go = (wc < NW_W);
        if (wc == NW_W - 6'd1) state_n = ROUND;
      end
`endif
      ROUND: begin
        kx_go = (wc < NW_W);
        // Decrypt enters ROUND with every word ready; encrypt waits on words.
        if (dec_q || ({1'b0, wc} >= need)) begin
          rnd_go = 1'b1;
          rc_n   = rc + 4'd1;
          if (rc == NR_W) state_n = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (kx_go) begin
      bus.kx_en  = 1'b1;
      bus.kx_idx = wc;
      wc_n       = wc + 6'd1;
      p_n        = (p == P_LAST) ? 3'd0 : p + 3'd1;
      if (p == 3'd0) begin
        bus.kx_kind = 2'd1;
        bus.kx_rcon = rcon;
        rcon_n      = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
      end else if (NK == 8 && p == 3'd4) begin
        bus.kx_kind = 2'd2;
      end
    end

    // rc counts issued rounds in both modes; decrypt maps it to NR-rc, so the
    // first issued round is always rc==0 and the last rc==NR.
    if (rnd_go) begin
      bus.rnd_en    = 1'b1;
      bus.rnd_idx   = dec_q ? (NR_W - rc) : rc;
      bus.rnd_first = (rc == 4'd0);
      bus.rnd_last  = (rc == NR_W);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    if (!reset) begin
      state <= IDLE;
      wc    <= 6'd0;
      p     <= 3'd0;
      rc    <= 4'd0;
      rcon  <= 8'h01;
`ifdef AES_SEQ_DECRYPT_EN
      dec_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      wc    <= wc_n;
      p     <= p_n;
      rc    <= rc_n;
      rcon  <= rcon_n;
`ifdef AES_SEQ_DECRYPT_EN
      dec_q <= dec_n;
`endif
    end
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Parametrised control sequencer for the iterative AES core. It is the successor to the fixed 10-round controller and supports AES-128, AES-192 and AES-256 selected at elaboration. It drives a one-word-per-cycle key expander and a one-round-per-cycle state datapath through a start/ready/done handshake. Rcon is generated in GF(2^8) instead of being decoded from state, and an optional decrypt ordering is available.

## Interface
Parameters:
- KEY_BITS, 128, key length; legal values are 128, 192 and 256, and any other value is an elaboration error.
- Derived values, not overridable: NK = KEY_BITS/32 (4, 6 or 8); NR = NK+6 (10, 12 or 14); NW = 4*(NR+1) (44, 52 or 60).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  request; accepted only when ready=1
- decrypt  in  1  mode, sampled on accept
- ready  out  1  idle, can accept start
- load_en  out  1  one-cycle pulse in the accept cycle; datapath latches key and text
- kx_en  out  1  expander computes word kx_idx this cycle
- kx_idx  out  6  word index, NK..NW-1
- kx_kind  out  2  0 = XOR only; 1 = RotWord+SubWord+Rcon; 2 = SubWord only
- kx_rcon  out  8  Rcon byte, valid when kx_kind=1
- rnd_en  out  1  datapath executes round rnd_idx this cycle
- rnd_idx  out  4  round number 0..NR
- rnd_first  out  1  AddRoundKey only (no Sub/Shift/Mix)
- rnd_last  out  1  skip MixColumns
- done  out  1  one-cycle pulse; result valid

## Operation
States are IDLE, EXPAND, ROUND and DONE.

IDLE:
- ready=1.
- start=1 pulses load_en, clears wc=NK, the phase counter and the round counter, sets rcon=8'h01 and latches the mode.
- Next state is ROUND for encrypt, EXPAND for decrypt.

Key expansion, in both EXPAND and ROUND:
- While wc<NW, assert kx_en with kx_idx=wc, then increment wc.
- A phase counter p cycles 0..NK-1 alongside wc; no divider is used.
- p==0: kx_kind=1, kx_rcon=current rcon. After use, rcon advances by xtime: rcon = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
- NK==8 and p==4: kx_kind=2.
- Otherwise kx_kind=0.

Encrypt (ROUND):
- Round counter rc runs 0..NR.
- In a cycle where wc >= 4*rc+4, assert rnd_en with rnd_idx=rc, then increment rc.
- At most one round issues per cycle. Expansion and rounds overlap.
- rnd_first=(rc==0); rnd_last=(rc==NR).
- After round NR issues, go to DONE.

Decrypt (EXPAND, then ROUND):
- EXPAND generates all words with no rnd_en, then moves to ROUND.
- ROUND issues rnd_idx = NR, NR-1, …, 0, one per cycle.
- rnd_first on round NR; rnd_last on round 0.
- After round 0 issues, go to DONE.

DONE: done=1 for one cycle, then IDLE.

Boundary rules:
- start while ready=0 is ignored and not queued.
- start in the DONE cycle is ignored. It is accepted on the following IDLE cycle.
- decrypt changing mid-operation has no effect.
- reset=0 in any state: next cycle is IDLE, all strobes are 0, rcon=8'h01.
- When words and a round are both available, both strobes assert in the same cycle.

## Timing
- Reset values: ready=1; done, load_en, kx_en, rnd_en, rnd_first and rnd_last all 0; kx_idx=0, kx_kind=0, kx_rcon=0, rnd_idx=0.
- All outputs are registered-state decodes. No combinational path from start or decrypt to any output except load_en (= ready & start).
- Cycle numbering: cycle 0 is the accept cycle (start sampled high in IDLE).
- Encrypt, NK=4: round 0 in cycle 1; round r in cycle 4r+1; words 4..43 in cycles 1..40; done in cycle 42.
- Encrypt, NK=6: round 0 in cycle 1; round r≥1 in cycle 4r-1; done in cycle 48.
- Encrypt, NK=8: round 0 in cycle 1, round 1 in cycle 2; round r≥2 in cycle 4r-3; done in cycle 54.
- Decrypt: expansion occupies cycles 1..NW-NK; rounds occupy the next NR+1 cycles; done follows. For NK=4 rounds are in cycles 41..51 and done is in cycle 52.
- Rcon sequence at p==0: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.

## Configuration
- AES_SEQ_DECRYPT_EN defined: the decrypt input is honoured and the EXPAND state plus reverse round ordering are compiled in.
- AES_SEQ_DECRYPT_EN undefined: the decrypt input is ignored and treated as 0, and EXPAND is not compiled in. Encrypt timing is identical in both builds.

## Test plan
- KEY_BITS=128, encrypt: start in cycle 0 -> rnd_en in cycles 1, 5, 9 … 41 with idx 0..10; rnd_last only at idx 10; kx_rcon at kx_idx 4, 8, …, 40 = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36; done in cycle 42; ready returns in cycle 43.
- KEY_BITS=256, encrypt: kx_kind=2 at kx_idx 12, 20, …, 52; kx_kind=1 at 8, 16, …, 56; rounds 0 and 1 in cycles 1 and 2; done in cycle 54.
- KEY_BITS=192, encrypt: kx_kind=1 at kx_idx 6, 12, …, 48 with rcon 01..80; done in cycle 48.
- Build with AES_SEQ_DECRYPT_EN, KEY_BITS=128, decrypt=1: no rnd_en in cycles 1..40; rnd_idx 10 down to 0 in cycles 41..51; rnd_first at idx 10; done in cycle 52. Build without the macro: same stimulus gives the encrypt timing.
- Drive start=1 continuously through an operation -> exactly one load_en per operation; the next accept happens in the cycle after the done cycle.
- Assert reset=0 in cycle 20 of an encrypt -> all strobes 0 and ready=1 the next cycle; a new start then reproduces the nominal timing with rcon restarting at 01.
